// File: rtl/fir_mac_pkg.sv
// Shared types and helpers for the FIR MAC controller: FSM state encoding and a
// constant ceil(log2) used to size the tap index and coefficient address.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_scale.sv
// Combinational output scaling: arithmetic right shift of the accumulator followed
// by saturation to OUT_WIDTH; FIR_MAC_CTRL_ROUND_EN adds round-half-up before the shift.
module fir_mac_scale #(
  parameter int P_DATA_WIDTH = 48,
  parameter int OUT_WIDTH    = 24,
  parameter int OUT_SHIFT    = 17
) (
  input  logic signed [P_DATA_WIDTH-1:0] acc_i,
  output logic signed [OUT_WIDTH-1:0]    data_o
);

  // One guard bit so the rounding offset can never wrap the accumulator.
  localparam int XW = P_DATA_WIDTH + 1;
  localparam logic signed [XW-1:0] MAX_V = $signed({{(XW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [XW-1:0] MIN_V = $signed({{(XW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shf;

  assign ext = {acc_i[P_DATA_WIDTH-1], acc_i};

`ifdef FIR_MAC_CTRL_ROUND_EN
  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic [XW-1:0] HALF = {{(XW-1){1'b0}}, 1'b1} << (OUT_SHIFT - 1);
      assign rnd = ext + $signed(HALF);
    end else begin : g_no_round
      assign rnd = ext;
    end
  endgenerate
`else
  assign rnd = ext;
`endif

  assign shf = rnd >>> OUT_SHIFT;

  always_comb begin
    data_o = shf[OUT_WIDTH-1:0];
    if (shf > MAX_V) begin
      data_o = MAX_V[OUT_WIDTH-1:0];
    end else if (shf < MIN_V) begin
      data_o = MIN_V[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequential FIR controller driving an external 1-cycle registered MAC, one tap per
// cycle. Define FIR_MAC_CTRL_ROUND_EN to round (half up) instead of truncating on output.
module fir_mac_ctrl
  import fir_mac_pkg::*;
#(
  parameter int TAPS         = 16,
  parameter int A_DATA_WIDTH = 25,
  parameter int B_DATA_WIDTH = 18,
  parameter int P_DATA_WIDTH = 48,
  parameter int OUT_WIDTH    = 24,
  parameter int OUT_SHIFT    = 17
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic signed [A_DATA_WIDTH-1:0] in_data,
  output logic                           in_ready,
  input  logic                           coef_wr_en,
  input  logic [clog2(TAPS)-1:0]         coef_wr_addr,
  input  logic signed [B_DATA_WIDTH-1:0] coef_wr_data,
  output logic                           coef_wr_ready,
  output logic                           mac_acc,
  output logic signed [A_DATA_WIDTH-1:0] mac_a,
  output logic signed [B_DATA_WIDTH-1:0] mac_b,
  input  logic signed [P_DATA_WIDTH-1:0] mac_p,
  output logic                           out_valid,
  output logic signed [OUT_WIDTH-1:0]    out_data
);

  localparam int KW = clog2(TAPS);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  state_e                         state_q, state_d;
  logic [KW-1:0]                  k_q, k_d;
  logic signed [A_DATA_WIDTH-1:0] d_q [TAPS];
  logic signed [B_DATA_WIDTH-1:0] c_q [TAPS];
  logic                           shift_en;
  logic                           out_load;
  logic                           coef_we;
  logic signed [OUT_WIDTH-1:0]    scaled;
  logic                           out_valid_q;
  logic signed [OUT_WIDTH-1:0]    out_data_q;

  assign coef_we = coef_wr_en && coef_wr_ready && (32'(coef_wr_addr) < TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // A same-edge coefficient write lands before RUN reads it, so that sample sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        d_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (shift_en) begin
        d_q[0] <= in_data;
        for (int i = 1; i < TAPS; i++) begin
          d_q[i] <= d_q[i-1];
        end
      end
      if (coef_we) begin
        c_q[coef_wr_addr] <= coef_wr_data;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    in_ready      = 1'b0;
    coef_wr_ready = 1'b0;
    mac_acc       = 1'b0;
    mac_a         = '0;
    mac_b         = '0;
    shift_en      = 1'b0;
    out_load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready      = 1'b1;
        coef_wr_ready = 1'b1;
        if (in_valid) begin
          shift_en = 1'b1;
          k_d      = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        mac_a   = d_q[k_q];
        mac_b   = c_q[k_q];
        mac_acc = (k_q != '0);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        out_load = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fir_mac_scale #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .OUT_SHIFT   (OUT_SHIFT)
  ) u_scale (
    .acc_i (mac_p),
    .data_o(scaled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_load;
      if (out_load) begin
        out_data_q <= scaled;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
